// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch widths, NOP encoding and the prefetch queue entry layout.
package riscv_pkg;
    localparam int PC_WIDTH = 32;
    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0]     inst;
        logic [PC_WIDTH-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/if_prefetch_fifo.sv
// if_prefetch_fifo: DEPTH-entry synchronous FIFO with flush; flush overrides push and pop.
module if_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk)
        if (push && !flush) mem[wr_ptr] <= wdata;
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/if_prefetch.sv
// if_prefetch: prefetching instruction-fetch front end with redirect flush.
// Define IF_PREFETCH_BYPASS_EN to forward a response straight to inst_* when the queue is empty.
module if_prefetch #(
    parameter int                  PC_WIDTH = riscv_pkg::PC_WIDTH,
    parameter int                  XLEN     = riscv_pkg::XLEN,
    parameter int                  DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_valid,
    input  logic [PC_WIDTH-1:0]        redirect_pc,
    output logic                       imem_req,
    output logic [PC_WIDTH-1:0]        imem_addr,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [XLEN-1:0]            imem_rdata,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [XLEN-1:0]            inst,
    output logic [PC_WIDTH-1:0]        inst_pc,
    output logic [PC_WIDTH-1:0]        inst_pcplus4,
    output logic [$clog2(DEPTH+1)-1:0] queue_count
);
    localparam int CW = $clog2(DEPTH+1);
    typedef struct packed {
        logic [XLEN-1:0]     inst;
        logic [PC_WIDTH-1:0] pc;
    } entry_t;
    entry_t wr_e, rd_e;
    logic run, grant, rsp, keep, bypass, head_valid, push, pop;
    logic [PC_WIDTH-1:0] fetch_pc, rsp_pc, target;
    logic [CW-1:0] outstanding, discard;
    logic [CW:0] inflight;
    assign target     = redirect_pc & ~PC_WIDTH'(3);
    assign inflight   = {1'b0, queue_count} + {1'b0, outstanding};
    assign imem_req   = run && !redirect_valid && (inflight < (CW+1)'(DEPTH));
    assign imem_addr  = fetch_pc;
    assign grant      = imem_req && imem_gnt;
    assign rsp        = imem_rvalid && (outstanding != '0);
    assign keep       = rsp && (discard == '0) && !redirect_valid;
    assign head_valid = queue_count != '0;
`ifdef IF_PREFETCH_BYPASS_EN
    assign bypass = keep && !head_valid;
`else
    assign bypass = 1'b0;
`endif
    assign inst_valid   = (head_valid || bypass) && !redirect_valid;
    assign pop          = head_valid && inst_valid && inst_ready;
    assign push         = keep && !(bypass && inst_ready);
    assign wr_e         = '{inst: imem_rdata, pc: rsp_pc};
    assign inst         = !inst_valid ? '0 : bypass ? imem_rdata : rd_e.inst;
    assign inst_pc      = !inst_valid ? '0 : bypass ? rsp_pc : rd_e.pc;
    assign inst_pcplus4 = inst_valid ? inst_pc + PC_WIDTH'(4) : '0;
    if_prefetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(entry_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_e),
        .rdata (rd_e),
        .count (queue_count)
    );
    // run holds imem_req low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            run <= 1'b1;
            if (redirect_valid) begin
                fetch_pc    <= target;
                rsp_pc      <= target;
                // discard is a subset of outstanding, so every remaining response becomes stale.
                discard     <= outstanding - CW'(rsp);
                outstanding <= outstanding - CW'(rsp);
            end else begin
                if (grant) fetch_pc <= fetch_pc + PC_WIDTH'(4);
                if (keep) rsp_pc <= rsp_pc + PC_WIDTH'(4);
                outstanding <= outstanding + CW'(grant) - CW'(rsp);
                if (rsp && discard != '0) discard <= discard - CW'(1);
            end
        end
    end
endmodule
